unidad_control_pila: RTL and testbench



---
 rtl/uc_pkg.sv | 35 +++
 rtl/pila_dir.sv | 48 ++++
 rtl/unidad_control_pila.sv | 153 +++++++++++++++
 tb/tb_unidad_control_pila.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared encodings for the microc control unit: opcodes, ALU selects,
// control states and sticky error codes.
package uc_pkg;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_LI   = 6'b001000;
  localparam logic [5:0] OP_ADD  = 6'b010000;
  localparam logic [5:0] OP_SUB  = 6'b001100;
  localparam logic [5:0] OP_AND  = 6'b010100;
  localparam logic [5:0] OP_OR   = 6'b011100;
  localparam logic [5:0] OP_BEQZ = 6'b000010;
  localparam logic [5:0] OP_J    = 6'b000011;
  localparam logic [5:0] OP_B    = 6'b000111;
  localparam logic [5:0] OP_JAL  = 6'b000100;
  localparam logic [5:0] OP_RET  = 6'b000101;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HALT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

endpackage

// File: rtl/pila_dir.sv
// Return-address stack: only the stack pointer is reset, entries keep their
// old contents; the top of stack reads as zero when empty.
module pila_dir #(
  parameter int DEPTH = 8,
  parameter int PCW   = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] din,
  output logic           full,
  output logic           empty,
  output logic [PCW-1:0] top
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  logic [SPW-1:0] sp;
  logic [PCW-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;

  assign full   = (sp == SPW'(DEPTH));
  assign empty  = (sp == '0);
  // Live pointer values are always below DEPTH, so the narrow index is exact.
  assign wr_idx = AW'(sp);
  assign rd_idx = AW'(sp - 1'b1);
  assign top    = empty ? '0 : mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/unidad_control_pila.sv
// Control unit for the microc datapath: combinational decode from opcode/z,
// jal/ret through a return-address stack, halt, and sticky error trapping.
module unidad_control_pila
  import uc_pkg::*;
#(
  parameter int OPW   = 6,
  parameter int ALUW  = 3,
  parameter int PCW   = 10,
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            z,
  input  logic [PCW-1:0]  pc_plus1,
  output logic            inm,
  output logic            abs,
  output logic            inc,
  output logic            we3,
  output logic            wez,
  output logic [ALUW-1:0] op,
  output logic            pc_en,
  output logic            s_ret,
  output logic [PCW-1:0]  ret_addr,
  output logic            halted,
  output logic [1:0]      err
);

  state_t         state, state_next;
  logic [1:0]     err_q, err_next;
  logic           push, pop, full, empty;
  logic [PCW-1:0] top;

  pila_dir #(
    .DEPTH(DEPTH),
    .PCW  (PCW)
  ) u_pila (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (pc_plus1),
    .full (full),
    .empty(empty),
    .top  (top)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RUN;
      err_q <= ERR_NONE;
    end else begin
      state <= state_next;
      err_q <= err_next;
    end
  end

  always_comb begin
    inm        = 1'b0;
    abs        = 1'b1;
    inc        = 1'b1;
    we3        = 1'b0;
    wez        = 1'b0;
    op         = ALUW'(ALU_PASS);
    s_ret      = 1'b0;
    pc_en      = 1'b1;
    push       = 1'b0;
    pop        = 1'b0;
    state_next = state;
    err_next   = err_q;

    if (reset) begin
      pc_en = 1'b0;
    end else if (state != S_RUN) begin
      pc_en = 1'b0;
    end else begin
      case (opcode)
        OPW'(OP_NOP): ;
        OPW'(OP_LI): begin
          inm = 1'b1;
          we3 = 1'b1;
        end
        OPW'(OP_ADD): begin
          we3 = 1'b1;
          wez = 1'b1;
          op  = ALUW'(ALU_ADD);
        end
        OPW'(OP_SUB): begin
          we3 = 1'b1;
          wez = 1'b1;
          op  = ALUW'(ALU_SUB);
        end
        OPW'(OP_AND): begin
          we3 = 1'b1;
          wez = 1'b1;
          op  = ALUW'(ALU_AND);
        end
        OPW'(OP_OR): begin
          we3 = 1'b1;
          wez = 1'b1;
          op  = ALUW'(ALU_OR);
        end
        OPW'(OP_BEQZ): begin
          if (z) begin
            abs = 1'b0;
            inc = 1'b0;
          end
        end
        OPW'(OP_J): begin
          abs = 1'b0;
          inc = 1'b0;
        end
        OPW'(OP_B): inc = 1'b0;
        // A faulting call or return leaves the PC and stack untouched.
        OPW'(OP_JAL): begin
          if (full) begin
            pc_en      = 1'b0;
            state_next = S_ERROR;
            err_next   = ERR_OVERFLOW;
          end else begin
            abs  = 1'b0;
            inc  = 1'b0;
            push = 1'b1;
          end
        end
        OPW'(OP_RET): begin
          if (empty) begin
            pc_en      = 1'b0;
            state_next = S_ERROR;
            err_next   = ERR_UNDERFLOW;
          end else begin
            s_ret = 1'b1;
            pop   = 1'b1;
          end
        end
        OPW'(OP_HALT): begin
          pc_en      = 1'b0;
          state_next = S_HALT;
        end
        default: begin
          pc_en      = 1'b0;
          state_next = S_ERROR;
          err_next   = ERR_ILLEGAL;
        end
      endcase
    end
  end

  assign ret_addr = reset ? '0 : top;
  assign halted   = (state == S_HALT);
  assign err      = err_q;

endmodule

// File: tb/tb_unidad_control_pila.sv
// Directed bench for unidad_control_pila: a queue-based reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_unidad_control_pila;

  localparam int OPW = 6, ALUW = 3, PCW = 10, DEPTH = 8;

  localparam logic [5:0] NOP = 6'b000000, LI = 6'b001000, ADD = 6'b010000;
  localparam logic [5:0] SUB = 6'b001100, ANDI = 6'b010100, ORI = 6'b011100;
  localparam logic [5:0] BEQZ = 6'b000010, JMP = 6'b000011, BR = 6'b000111;
  localparam logic [5:0] JAL = 6'b000100, RET = 6'b000101, HLT = 6'b111111;
  localparam logic [5:0] BAD = 6'b101010;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [OPW-1:0]  opcode = '0;
  logic            z = 1'b0;
  logic [PCW-1:0]  pc_plus1 = '0;
  logic            inm, abs, inc, we3, wez, pc_en, s_ret, halted;
  logic [ALUW-1:0] op;
  logic [PCW-1:0]  ret_addr;
  logic [1:0]      err;

  int n_cmp = 0;
  int n_bad = 0;

  unidad_control_pila #(.OPW(OPW), .ALUW(ALUW), .PCW(PCW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .z(z), .pc_plus1(pc_plus1),
    .inm(inm), .abs(abs), .inc(inc), .we3(we3), .wez(wez), .op(op),
    .pc_en(pc_en), .s_ret(s_ret), .ret_addr(ret_addr), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 = running, 1 = halted, 2 = error.
  int            m_mode = 0;
  int            m_err = 0;
  logic [PCW-1:0] m_stack[$];

  function automatic bit is_alu(input logic [5:0] o);
    return o == ADD || o == SUB || o == ANDI || o == ORI;
  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    return o == NOP || o == LI || is_alu(o) || o == BEQZ || o == JMP ||
           o == BR || o == JAL || o == RET || o == HLT;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0;
      m_err  = 0;
      m_stack.delete();
    end else if (m_mode == 0) begin
      if (!is_legal(opcode)) begin
        m_mode = 2; m_err = 3;
      end else if (opcode == HLT) begin
        m_mode = 1;
      end else if (opcode == JAL) begin
        if (m_stack.size() == DEPTH) begin m_mode = 2; m_err = 1; end
        else m_stack.push_back(pc_plus1);
      end else if (opcode == RET) begin
        if (m_stack.size() == 0) begin m_mode = 2; m_err = 2; end
        else void'(m_stack.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    bit e_inm, e_abs, e_inc, e_we3, e_wez, e_pc, e_sret, jump_abs;
    logic [2:0] e_op;
    logic [PCW-1:0] e_ret;
    bit running, call_ok, ret_ok;
    running  = !reset && m_mode == 0;
    call_ok  = running && opcode == JAL && m_stack.size() < DEPTH;
    ret_ok   = running && opcode == RET && m_stack.size() > 0;
    jump_abs = running && (opcode == JMP || call_ok || (opcode == BEQZ && z));
    e_inm  = running && opcode == LI;
    e_we3  = running && (opcode == LI || is_alu(opcode));
    e_wez  = running && is_alu(opcode);
    e_abs  = !jump_abs;
    e_inc  = !(jump_abs || (running && opcode == BR));
    e_sret = ret_ok;
    e_pc   = running && is_legal(opcode) && opcode != HLT &&
             !(opcode == JAL && !call_ok) && !(opcode == RET && !ret_ok);
    e_op   = !running ? 3'b000 : opcode == ADD ? 3'b010 : opcode == SUB ? 3'b011 :
             opcode == ANDI ? 3'b100 : opcode == ORI ? 3'b101 : 3'b000;
    e_ret  = (reset || m_stack.size() == 0) ? '0 : m_stack[$];
    chk("inm", inm, e_inm);
    chk("abs", abs, e_abs);
    chk("inc", inc, e_inc);
    chk("we3", we3, e_we3);
    chk("wez", wez, e_wez);
    chk("op", op, e_op);
    chk("pc_en", pc_en, e_pc);
    chk("s_ret", s_ret, e_sret);
    chk("ret_addr", ret_addr, e_ret);
    chk("halted", halted, m_mode == 1);
    chk("err", err, m_err);
  end

  task automatic step(input logic r, input logic [5:0] o, input logic zz, input logic [PCW-1:0] p);
    @(posedge clk);
    #1;
    reset = r; opcode = o; z = zz; pc_plus1 = p;
    @(negedge clk);
    #1;
  endtask

  initial begin
    step(1, NOP, 0, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_ret_addr", ret_addr, 0);
    step(0, NOP, 0, 0);
    chk("rst_err", err, 0);
    chk("rst_halted", halted, 0);

    step(0, LI, 0, 0);
    chk("li_ctl", {inm, we3, wez, op, pc_en}, {1'b1, 1'b1, 1'b0, 3'b000, 1'b1});
    step(0, ADD, 0, 0);
    chk("add_ctl", {inm, we3, wez, op, pc_en}, {1'b0, 1'b1, 1'b1, 3'b010, 1'b1});
    step(0, SUB, 0, 0);
    chk("sub_ctl", {inm, we3, wez, op, pc_en}, {1'b0, 1'b1, 1'b1, 3'b011, 1'b1});
    step(0, ANDI, 0, 0);
    step(0, ORI, 1, 0);
    chk("or_op", op, 3'b101);
    step(0, BEQZ, 1, 0);
    chk("beqz_taken", {abs, inc}, 2'b00);
    step(0, BEQZ, 0, 0);
    chk("beqz_not", {abs, inc}, 2'b11);
    step(0, JMP, 0, 0);
    step(0, BR, 0, 0);
    chk("b_ctl", {abs, inc}, 2'b10);

    step(0, JAL, 0, 10'h05);
    chk("jal1_ctl", {abs, inc, pc_en}, 3'b001);
    step(0, JAL, 0, 10'h21);
    step(0, RET, 0, 0);
    chk("ret1_addr", ret_addr, 10'h21);
    chk("ret1_sret", s_ret, 1);
    step(0, RET, 0, 0);
    chk("ret2_addr", ret_addr, 10'h05);
    chk("ret2_sret", s_ret, 1);
    step(0, NOP, 0, 0);
    chk("empty_addr", ret_addr, 0);

    step(0, RET, 0, 0);
    chk("uflow_pc_en", pc_en, 0);
    step(0, ADD, 0, 0);
    chk("uflow_err", err, 2);
    chk("uflow_we3", we3, 0);

    step(1, NOP, 0, 0);
    step(0, JAL, 0, 10'h33);
    step(1, NOP, 0, 0);
    step(0, RET, 0, 0);
    chk("midcall_ret", pc_en, 0);
    step(0, NOP, 0, 0);
    chk("midcall_err", err, 2);

    step(1, NOP, 0, 0);
    step(0, BAD, 0, 0);
    chk("illegal_pc_en", pc_en, 0);
    step(0, JAL, 0, 10'h01);
    chk("illegal_err", err, 3);
    step(0, BAD, 0, 0);
    chk("sticky_err", err, 3);

    step(1, NOP, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step(0, JAL, 0, PCW'(i + 1));
      if (i == 8) begin
        chk("oflow_pc_en", pc_en, 0);
        chk("oflow_top", ret_addr, 10'h08);
      end else begin
        chk("push_pc_en", pc_en, 1);
      end
    end
    step(0, ADD, 0, 0);
    chk("oflow_err", err, 1);
    chk("oflow_we3", we3, 0);

    step(1, NOP, 0, 0);
    step(0, NOP, 0, 0);
    chk("reset_err", err, 0);
    chk("reset_sp", ret_addr, 0);

    step(0, HLT, 0, 0);
    chk("halt_pc_en", pc_en, 0);
    chk("halt_same_cycle", halted, 0);
    step(0, LI, 0, 0);
    chk("halted", halted, 1);
    chk("halted_we3", we3, 0);
    step(0, JAL, 0, 10'h12);
    chk("halted_pc_en", pc_en, 0);
    step(1, NOP, 0, 0);
    step(0, LI, 0, 0);
    chk("resume_we3", we3, 1);
    chk("resume_halted", halted, 0);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
